// File: rtl/axis_red_pitaya_4ch_decim.sv
// Four-lane boxcar decimator for the Red Pitaya ADC stream: sums 2^L beats per lane
// and emits the arithmetic average as a sign-extended 14-bit value on an AXI-Stream port.
module axis_red_pitaya_4ch_decim #(
    parameter int unsigned MAX_LOG2 = 8
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  cfg_log2,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        overrun
);

    localparam int unsigned LANES  = 4;
    localparam int unsigned ADC_W  = 14;
    localparam int unsigned LANE_W = 16;
    localparam int unsigned ACC_W  = ADC_W + MAX_LOG2;
    localparam int unsigned CNT_W  = MAX_LOG2;

    logic signed [ACC_W-1:0] acc     [LANES];
    logic signed [ACC_W-1:0] sum     [LANES];
    logic signed [ACC_W-1:0] shifted [LANES];
    logic signed [ADC_W-1:0] x       [LANES];

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last_idx;
    logic [CNT_W:0]   n_full;
    logic [3:0]       le;
    logic [3:0]       le_cfg;
    logic [63:0]      res_data;
    logic             last;
    logic             complete;
    logic             load;
    logic             drop;

    // The ADC stream is never throttled.
    assign s_axis_tready = 1'b1;

    // Block-length decode, per-lane sums and the shifted averages.
    always_comb begin
        le_cfg   = (32'(cfg_log2) > MAX_LOG2) ? 4'(MAX_LOG2) : cfg_log2;
        n_full   = (CNT_W+1)'(1) << le;
        last_idx = CNT_W'(n_full - (CNT_W+1)'(1));
        last     = (cnt == last_idx);
        complete = s_axis_tvalid && last;
        load     = complete && (!m_axis_tvalid || m_axis_tready);
        drop     = complete && m_axis_tvalid && !m_axis_tready;
        res_data = '0;
        for (int k = 0; k < LANES; k++) begin
            x[k]       = signed'(s_axis_tdata[LANE_W*k +: ADC_W]);
            sum[k]     = acc[k] + {{MAX_LOG2{x[k][ADC_W-1]}}, x[k]};
            shifted[k] = sum[k] >>> le;
            res_data[LANE_W*k +: LANE_W] =
                {{(LANE_W-ADC_W){shifted[k][ADC_W-1]}}, shifted[k][ADC_W-1:0]};
        end
    end

    // Accumulators, sample counter and the exponent latched per block.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int k = 0; k < LANES; k++) acc[k] <= '0;
            cnt <= '0;
            le  <= le_cfg;
        end else if (s_axis_tvalid) begin
            if (last) begin
                for (int k = 0; k < LANES; k++) acc[k] <= '0;
                cnt <= '0;
                le  <= le_cfg;
            end else begin
                for (int k = 0; k < LANES; k++) acc[k] <= sum[k];
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Single output register; a result arriving while stalled is discarded.
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (load) begin
                m_axis_tdata  <= res_data;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (drop) overrun <= 1'b1;
        end
    end

endmodule

// File: doc/axis_red_pitaya_4ch_decim.md
AXIS_RED_PITAYA_4CH_DECIM -- requirements
Module: axis_red_pitaya_4ch_decim

Interface
REQ-001: The block SHALL have one clock and a synchronous, active-high reset.
REQ-002: Parameter MAX_LOG2, default 8, SHALL set the largest decimation exponent.
REQ-003: Port aclk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004: Port areset, input, 1 bit: synchronous, active-high reset.
REQ-005: Port cfg_log2, input, 4 bits: requested decimation exponent L, giving ratio N = 2^L.
REQ-006: Port s_axis_tdata, input, 64 bits: four lanes of 16 bits; lane k is bits [16k+15:16k]; bits [13:0] of each lane are signed 14-bit ADC samples; bits [15:14] SHALL be ignored.
REQ-007: Port s_axis_tvalid, input, 1 bit: input beat valid.
REQ-008: Port s_axis_tready, output, 1 bit: SHALL be constant 1; the ADC stream has no backpressure.
REQ-009: Port m_axis_tdata, output, 64 bits: four 16-bit lanes, each holding a sign-extended 14-bit average.
REQ-010: Port m_axis_tvalid, output, 1 bit: output beat valid.
REQ-011: Port m_axis_tready, input, 1 bit: downstream ready.
REQ-012: Port overrun, output, 1 bit: sticky flag, set when a completed result is dropped.

Function
REQ-013: The effective exponent Le SHALL be min(cfg_log2, MAX_LOG2).
- Le SHALL be latched into an internal register only at reset and at each block boundary (the cycle the sample counter wraps to 0).
- A cfg_log2 change in mid-block SHALL NOT affect the block in progress.
REQ-014: Each channel SHALL have a signed accumulator of 14+MAX_LOG2 bits; all arithmetic SHALL be two's complement with sign extension and no saturation.
REQ-015: A sample counter cnt (MAX_LOG2 bits) SHALL advance only on cycles where s_axis_tvalid=1; with s_axis_tvalid=0, cnt and the accumulators SHALL hold.
REQ-016: On an accepted beat with cnt < N-1:
- acc_k <= acc_k + x_k.
- cnt <= cnt + 1.
REQ-017: On an accepted beat with cnt == N-1, the block is complete:
- result_k = (acc_k + x_k) arithmetically shifted right by Le, truncated to 14 bits.
- acc_k <= 0 and cnt <= 0.
- The latched exponent reloads from cfg_log2 (per REQ-013).
REQ-018: With Le=0 (N=1), every accepted beat SHALL complete a block; the output SHALL equal the input lanes sign-extended.
REQ-019: A completed result SHALL appear on m_axis_tdata with m_axis_tvalid=1 on the cycle after the completing beat (latency 1 clock).
REQ-020: The output register SHALL load a completed result when m_axis_tvalid=0, or when m_axis_tvalid=1 and m_axis_tready=1 in the same cycle (simultaneous accept-and-load; m_axis_tvalid stays 1).
REQ-021: If a result completes while m_axis_tvalid=1 and m_axis_tready=0:
- The new result SHALL be dropped.
- The held output SHALL remain unchanged.
- overrun SHALL be set to 1.
REQ-022: m_axis_tdata and m_axis_tvalid SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023: m_axis_tvalid SHALL deassert on the cycle after a handshake (m_axis_tvalid=1 and m_axis_tready=1) unless a new result loads in that handshake cycle.
REQ-024: Accumulation SHALL continue regardless of output stall; the input is never stalled.
REQ-025: overrun SHALL clear only on reset.

Reset
REQ-026: While areset=1, on each rising edge of aclk the block SHALL set:
- acc_k <= 0 and cnt <= 0.
- m_axis_tvalid <= 0 and m_axis_tdata <= 0.
- overrun <= 0.
- Latched exponent <= min(cfg_log2, MAX_LOG2).
REQ-027: Reset asserted mid-block SHALL discard the partial sums; the first beat after reset deasserts SHALL start a new block at cnt=0.
REQ-028: s_axis_tready SHALL be 1 during and after reset.

Verification
REQ-029: Le=0; input lanes 0x1FFF, 0x2000, 0x0001, 0x3FFF on consecutive valid beats -> output lanes 0x1FFF, 0xE000, 0x0001, 0xFFFF, each 1 cycle after its input.
REQ-030: Le=2; four beats of lane0 = 100, 200, 300, 401 (other lanes -8) -> single output with lane0 = 250 and other lanes 0xFFF8, valid 1 cycle after the 4th beat.
REQ-031: Le=8; 256 beats of all lanes = -8192 -> output lanes 0xE000 (no wrap); 256 beats of +8191 -> lanes 0x1FFF.
REQ-032: Le=1 with m_axis_tready=0 for 6 beats -> first result held unchanged, second and third results dropped, overrun=1; after m_axis_tready=1, one handshake, then m_axis_tvalid=0.
REQ-033: Le=2; cfg_log2 changed to 0 after the 2nd beat -> 4-beat average still produced, then per-beat outputs; cfg_log2=15 -> behaves as Le=8.
REQ-034: Reset pulse after 3 of 4 beats (Le=2) -> partial sum discarded; next 4 beats of 40 -> output 40; overrun=0.
